// File: rtl/sysref_ctrl_pkg.sv
// Shared types and default constants for the SYSREF alignment controller.
package sysref_ctrl_pkg;

  localparam int unsigned STATE_W           = 3;
  localparam int unsigned DEF_SYSREF_PERIOD = 256;
  localparam int unsigned DEF_LOCK_COUNT    = 4;
  localparam int unsigned DEF_CNT_W         = 16;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_MEASURE = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_ERROR   = 3'd4
  } state_e;

endpackage

// File: rtl/sysref_edge_det.sv
// Double register of the already-synchronous SYSREF and single-cycle rise detect.
module sysref_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise_c
);

  logic d1_q, d1_d;
  logic d2_q, d2_d;

  always_comb begin
    d1_d = sig_in;
    d2_d = d1_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d1_q <= 1'b0;
      d2_q <= 1'b0;
    end else begin
      d1_q <= d1_d;
      d2_q <= d2_d;
    end
  end

  assign rise_c = d1_q & ~d2_q;

endmodule

// File: rtl/sysref_align_ctrl.sv
// Measures SYSREF interval, locks after LOCK_COUNT matching intervals, then forwards aligned strobes.
// Optional SYSREF_REALIGN_EN: a mismatch while locked re-enters MEASURE instead of ERROR.
module sysref_align_ctrl
  import sysref_ctrl_pkg::*;
#(
  parameter int unsigned SYSREF_PERIOD = DEF_SYSREF_PERIOD,
  parameter int unsigned LOCK_COUNT    = DEF_LOCK_COUNT,
  parameter int unsigned CNT_W         = DEF_CNT_W
) (
  input  logic               pl_clk,
  input  logic               pl_rst,
  input  logic               sysref_in,
  input  logic               arm,
  input  logic               disarm,
  output logic               sysref_pulse,
  output logic               locked,
  output logic               error,
  output logic [STATE_W-1:0] state,
  output logic [CNT_W-1:0]   last_interval
);

  localparam int unsigned       GOOD_W   = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]  PERIOD_C = CNT_W'(SYSREF_PERIOD);
  localparam logic [GOOD_W-1:0] LOCK_C   = GOOD_W'(LOCK_COUNT);

  logic rise_c;
  logic match_c;
  logic sat_c;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  last_interval_q, last_interval_d;
  logic [GOOD_W-1:0] good_q, good_d;
  logic              pend_q, pend_d;
  logic              pulse_q, pulse_d;
  logic              locked_q, locked_d;
  logic              error_q, error_d;

  sysref_edge_det u_edge (
    .clk    (pl_clk),
    .rst    (pl_rst),
    .sig_in (sysref_in),
    .rise_c (rise_c)
  );

  assign match_c = (cnt_q == PERIOD_C);
  assign sat_c   = (cnt_q == CNT_MAX);

  // Interval counter restarts at 1 on each rise and sticks at all-ones when SYSREF goes missing.
  always_comb begin
    cnt_d           = cnt_q;
    last_interval_d = last_interval_q;
    if (rise_c) begin
      cnt_d           = CNT_W'(1);
      last_interval_d = cnt_q;
    end else if (!sat_c) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    good_d  = good_q;
    pend_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (arm) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (arm) begin
          good_d = '0;
        end else if (rise_c) begin
          state_d = ST_MEASURE;
          good_d  = '0;
        end
      end
      ST_MEASURE: begin
        if (arm) begin
          state_d = ST_ARMED;
          good_d  = '0;
        end else if (sat_c) begin
          state_d = ST_ERROR;
        end else if (rise_c) begin
          if (match_c) begin
            good_d = good_q + GOOD_W'(1);
            if (good_q + GOOD_W'(1) == LOCK_C) state_d = ST_LOCKED;
          end else begin
            good_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (sat_c) begin
          state_d = ST_ERROR;
        end else if (rise_c) begin
          if (match_c) begin
            pend_d = 1'b1;
          end else begin
`ifdef SYSREF_REALIGN_EN
            state_d = ST_MEASURE;
            good_d  = '0;
`else
            state_d = ST_ERROR;
`endif
          end
        end
      end
      ST_ERROR: begin
        if (arm) begin
          state_d = ST_ARMED;
          good_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        good_d  = '0;
      end
    endcase

    // Disarm beats every other request, including a strobe already in flight.
    if (disarm) begin
      state_d = ST_IDLE;
      good_d  = '0;
      pend_d  = 1'b0;
    end

    pulse_d  = pend_q & ~disarm;
    locked_d = (state_d == ST_LOCKED);
    error_d  = (state_d == ST_ERROR);
  end

  always_ff @(posedge pl_clk or posedge pl_rst) begin
    if (pl_rst) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      last_interval_q <= '0;
      good_q          <= '0;
      pend_q          <= 1'b0;
      pulse_q         <= 1'b0;
      locked_q        <= 1'b0;
      error_q         <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      last_interval_q <= last_interval_d;
      good_q          <= good_d;
      pend_q          <= pend_d;
      pulse_q         <= pulse_d;
      locked_q        <= locked_d;
      error_q         <= error_d;
    end
  end

  assign sysref_pulse  = pulse_q;
  assign locked        = locked_q;
  assign error         = error_q;
  assign state         = state_q;
  assign last_interval = last_interval_q;

endmodule

// File: tb/tb_sysref_align_ctrl.sv
// Directed bench for sysref_align_ctrl with SYSREF_PERIOD=16, LOCK_COUNT=4, CNT_W=6.
module tb_sysref_align_ctrl;

  localparam int unsigned PERIOD = 16;
  localparam int unsigned CW     = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sysref_in = 1'b0;
  logic          arm = 1'b0;
  logic          disarm = 1'b0;
  logic          sysref_pulse;
  logic          locked;
  logic          error;
  logic [2:0]    state;
  logic [CW-1:0] last_interval;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = -1;
  int samp_cyc = 0;

  sysref_align_ctrl #(
    .SYSREF_PERIOD (PERIOD),
    .LOCK_COUNT    (4),
    .CNT_W         (CW)
  ) dut (
    .pl_clk        (clk),
    .pl_rst        (rst),
    .sysref_in     (sysref_in),
    .arm           (arm),
    .disarm        (disarm),
    .sysref_pulse  (sysref_pulse),
    .locked        (locked),
    .error         (error),
    .state         (state),
    .last_interval (last_interval)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sysref_pulse) begin
      pulse_cnt      = pulse_cnt + 1;
      last_pulse_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total = total + 1;
    if (got !== exp) begin
      bad = bad + 1;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle SYSREF, then n-1 low cycles; samp_cyc is the edge that captures it.
  task automatic sref_period(input int n);
    sysref_in = 1'b1;
    samp_cyc  = cyc + 1;
    step();
    sysref_in = 1'b0;
    repeat (n - 1) step();
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  initial begin
    int n;
    int act;
    int pc;

    step();
    step();
    check("rst_state", 32'(state), 32'd0);
    check("rst_outs", {sysref_pulse, locked, error}, 32'd0);
    check("rst_last", 32'(last_interval), 32'd0);
    rst = 1'b0;
    step();

    // Rise while idle is ignored; arm+disarm together lands in IDLE.
    sref_period(PERIOD);
    check("idle_rise", 32'(state), 32'd0);
    do_arm();
    check("armed", 32'(state), 32'd1);
    arm = 1'b1;
    disarm = 1'b1;
    step();
    arm = 1'b0;
    disarm = 1'b0;
    check("arm_disarm", 32'(state), 32'd0);
    do_arm();
    check("rearmed", 32'(state), 32'd1);

    sref_period(PERIOD);
    check("measure_1st", 32'(state), 32'd2);
    repeat (3) sref_period(PERIOD);
    check("measure_4th", 32'(state), 32'd2);
    sref_period(PERIOD);
    check("lock_state", 32'(state), 32'd3);
    check("lock_flag", 32'(locked), 32'd1);
    check("lock_no_pulse", 32'(pulse_cnt), 32'd0);
    check("last_int16", 32'(last_interval), 32'd16);

    sref_period(PERIOD);
    check("pulse6_cnt", 32'(pulse_cnt), 32'd1);
    check("pulse6_lat", 32'(last_pulse_cyc), 32'(samp_cyc + 2));
    sref_period(PERIOD);
    check("pulse7_cnt", 32'(pulse_cnt), 32'd2);
    check("pulse7_lat", 32'(last_pulse_cyc), 32'(samp_cyc + 2));

    // Stretched interval of 17 measured at the following rise.
    sref_period(PERIOD + 1);
    check("pulse8_cnt", 32'(pulse_cnt), 32'd3);
    sref_period(PERIOD);
    check("bad_last_int", 32'(last_interval), 32'd17);
    check("bad_no_pulse", 32'(pulse_cnt), 32'd3);
    check("bad_unlocked", 32'(locked), 32'd0);
`ifdef SYSREF_REALIGN_EN
    check("realign_state", 32'(state), 32'd2);
    check("realign_err", 32'(error), 32'd0);
    repeat (4) sref_period(PERIOD);
`else
    check("err_state", 32'(state), 32'd4);
    check("err_flag", 32'(error), 32'd1);
    do_arm();
    check("err_arm_state", 32'(state), 32'd1);
    check("err_arm_flag", 32'(error), 32'd0);
    repeat (5) sref_period(PERIOD);
`endif
    check("relock_state", 32'(state), 32'd3);
    check("relock_no_pulse", 32'(pulse_cnt), 32'd3);

    // SYSREF stops: ERROR on the edge after the counter reaches 63.
    act = samp_cyc + 1;
    n = 0;
    while (state != 3'd4 && n < 200) begin
      step();
      n = n + 1;
    end
    check("sat_state", 32'(state), 32'd4);
    check("sat_cycle", 32'(cyc), 32'(act + 63));
    check("sat_err", {locked, error}, 32'd1);
    check("sat_no_pulse", 32'(pulse_cnt), 32'd3);

    do_arm();
    repeat (5) sref_period(PERIOD);
    check("pre_rst_lock", 32'(state), 32'd3);
    pc = pulse_cnt;

    // Asynchronous reset mid-lock with a matching rise in flight.
    sysref_in = 1'b1;
    step();
    sysref_in = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_outs", {sysref_pulse, locked, error}, 32'd0);
    check("arst_last", 32'(last_interval), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    check("post_rst_state", 32'(state), 32'd0);
    repeat (3) step();
    check("post_rst_pulse", 32'(pulse_cnt), 32'(pc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
